// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the low-frequency measurement sequencer.
package freq_meas_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRD_ARM  = 3'd1,
        PRD_WAIT = 3'd2,
        DIV_ARM  = 3'd3,
        DIV_WAIT = 3'd4,
        ERR      = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Result status codes
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ZERO    = 2'd2;

    // Datapath widths
    localparam int PRD_W  = 10;
    localparam int FREQ_W = 20;

    // Microseconds per second: numerator of freq_hz = 1e6 / period_us
    localparam logic [FREQ_W-1:0] DIVIDEND = 20'd1_000_000;

endpackage

// File: rtl/us_timer.sv
// Microsecond timer: a prescaler divides clk down to 1 us ticks and a
// saturating counter accumulates elapsed microseconds while enabled.
module us_timer #(
    parameter int CLK_US_COUNT = 100,
    parameter int MAX_US       = 1100,
    parameter int PRE_W        = (CLK_US_COUNT > 1) ? $clog2(CLK_US_COUNT) : 1,
    parameter int US_W         = $clog2(MAX_US + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    output logic [US_W-1:0] us_count,
    output logic            tick
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_US_COUNT - 1);
    localparam logic [US_W-1:0]  US_SAT   = US_W'(MAX_US);

    logic [PRE_W-1:0] pre;

    assign tick = en && (pre == PRE_LAST);

    // Prescaler: counts clk cycles within the current microsecond
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (clr) begin
            pre <= '0;
        end else if (en) begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    // Microsecond counter: advances on each prescaler wrap, holds at MAX_US
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            us_count <= '0;
        end else if (clr) begin
            us_count <= '0;
        end else if (tick && (us_count != US_SAT)) begin
            us_count <= us_count + 1'b1;
        end
    end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Low-frequency measurement sequencer: runs the period counter, guards it
// with a microsecond timeout, then runs the shared divider to turn the
// period into a frequency and publishes it with a one-cycle done tick.
module freq_meas_ctrl
    import freq_meas_pkg::*;
#(
    parameter int                CLK_US_COUNT = 100,
    parameter int                TIMEOUT_US   = 1100,
    parameter logic [FREQ_W-1:0] DIVIDEND     = freq_meas_pkg::DIVIDEND
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    output logic              prd_start,
    output logic              prd_clr,
    input  logic              prd_ready,
    input  logic              prd_done_tick,
    input  logic [PRD_W-1:0]  prd,
    output logic              div_start,
    output logic [FREQ_W-1:0] div_dvnd,
    output logic [FREQ_W-1:0] div_dvsr,
    input  logic              div_ready,
    input  logic              div_done_tick,
    input  logic [FREQ_W-1:0] div_quo,
    output logic              busy,
    output logic              done_tick,
    output logic [FREQ_W-1:0] freq,
    output logic [1:0]        err
);

    localparam int              US_W     = $clog2(TIMEOUT_US + 1);
    localparam logic [US_W-1:0] US_TO_M1 = US_W'(TIMEOUT_US - 1);

    state_t           state;
    logic [PRD_W-1:0] prd_reg;
    logic [US_W-1:0]  us_count;
    logic             us_tick;
    logic             tmr_clr;
    logic             tmr_en;
    logic             to_hit;

    // The timer is zeroed while arming, so counting starts with prd_start
    assign tmr_clr = (state == PRD_ARM);
    assign tmr_en  = (state == PRD_WAIT);

    us_timer #(
        .CLK_US_COUNT (CLK_US_COUNT),
        .MAX_US       (TIMEOUT_US),
        .US_W         (US_W)
    ) u_us_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .us_count (us_count),
        .tick     (us_tick)
    );

    // Timeout flag: set on the tick that carries the timer onto TIMEOUT_US,
    // so the FSM tests a single flop instead of a wide compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_hit <= 1'b0;
        end else if (tmr_clr) begin
            to_hit <= 1'b0;
        end else if (us_tick && (us_count == US_TO_M1)) begin
            to_hit <= 1'b1;
        end
    end

    // Sequencer FSM with registered start/clear pulses and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prd_reg   <= '0;
            freq      <= '0;
            err       <= ERR_NONE;
            prd_start <= 1'b0;
            prd_clr   <= 1'b0;
            div_start <= 1'b0;
        end else begin
            prd_start <= 1'b0;
            prd_clr   <= 1'b0;
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= PRD_ARM;
                end
                PRD_ARM: begin
                    if (prd_ready) begin
                        prd_start <= 1'b1;
                        state     <= PRD_WAIT;
                    end
                end
                PRD_WAIT: begin
                    // A result arriving in the timeout cycle is still accepted
                    if (prd_done_tick) begin
                        prd_reg <= prd;
                        if (prd == '0) begin
                            err   <= ERR_ZERO;
                            state <= ERR;
                        end else begin
                            state <= DIV_ARM;
                        end
                    end else if (to_hit) begin
                        prd_clr <= 1'b1;
                        err     <= ERR_TIMEOUT;
                        state   <= ERR;
                    end
                end
                DIV_ARM: begin
                    if (div_ready) begin
                        div_start <= 1'b1;
                        state     <= DIV_WAIT;
                    end
                end
                DIV_WAIT: begin
                    if (div_done_tick) begin
                        freq  <= div_quo;
                        err   <= ERR_NONE;
                        state <= DONE;
                    end
                end
                ERR: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= cont ? PRD_ARM : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done_tick = (state == DONE);
    assign div_dvnd  = DIVIDEND;
    assign div_dvsr  = {{(FREQ_W - PRD_W){1'b0}}, prd_reg};

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: behavioural period-counter and divider models,
// a scoreboard of expected {freq, err} pairs popped on each done_tick.
module tb_freq_meas_ctrl;

    localparam int CLK_US  = 10;
    localparam int TO_US   = 1100;
    localparam int TC      = CLK_US * TO_US;
    localparam int DIV_LAT = 22;
    localparam int DVND    = 1_000_000;

    typedef struct {
        logic [19:0] f;
        logic [1:0]  e;
    } exp_t;

    typedef struct {
        int         dly;
        logic [9:0] val;
    } pm_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cont;
    logic        prd_start;
    logic        prd_clr;
    logic        prd_ready = 1'b1;
    logic        prd_done_tick = 1'b0;
    logic [9:0]  prd = '0;
    logic        div_start;
    logic [19:0] div_dvnd;
    logic [19:0] div_dvsr;
    logic        div_ready = 1'b1;
    logic        div_done_tick = 1'b0;
    logic [19:0] div_quo = '0;
    logic        busy;
    logic        done_tick;
    logic [19:0] freq;
    logic [1:0]  err;

    int n_total = 0;
    int n_bad   = 0;

    // monitor counters and timestamps
    int cyc = 0;
    int n_prd_start = 0, n_prd_clr = 0, n_div_start = 0, n_done = 0, n_viol = 0;
    int t_prd_start = 0, t_prd_clr = 0, t_done = 0;
    logic [19:0] last_dvsr = '0;

    // model state
    exp_t sb_q[$];
    pm_t  pm_q[$];
    pm_t  pm_e;
    exp_t sb_e;
    int   pm_cnt = 0, dv_cnt = 0, pm_hold = 0, dv_hold = 0;
    int   cfg_prd_hold = 0, cfg_div_hold = 0;
    logic pm_active = 1'b0, pm_never = 1'b0, dv_active = 1'b0, stray_req = 1'b0;
    logic [9:0]  pm_val = '0;
    logic [19:0] dv_res = '0;
    logic [19:0] exp_freq = '0;

    freq_meas_ctrl #(
        .CLK_US_COUNT (CLK_US),
        .TIMEOUT_US   (TO_US)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cont          (cont),
        .prd_start     (prd_start),
        .prd_clr       (prd_clr),
        .prd_ready     (prd_ready),
        .prd_done_tick (prd_done_tick),
        .prd           (prd),
        .div_start     (div_start),
        .div_dvnd      (div_dvnd),
        .div_dvsr      (div_dvsr),
        .div_ready     (div_ready),
        .div_done_tick (div_done_tick),
        .div_quo       (div_quo),
        .busy          (busy),
        .done_tick     (done_tick),
        .freq          (freq),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return n_done;
            1:       return n_prd_start;
            default: return n_div_start;
        endcase
    endfunction

    // bounded wait for an event counter; an expired budget is a failed check
    task automatic wait_evt(input int which, input int target, input int budget, input string tag);
        int n = 0;
        while (cnt_of(which) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, cnt_of(which), target);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [19:0] f, input logic [1:0] e);
        sb_e.f = f;
        sb_e.e = e;
        sb_q.push_back(sb_e);
        exp_freq = f;
    endtask

    task automatic push_prd(input int dly, input logic [9:0] val);
        pm_e.dly = dly;
        pm_e.val = val;
        pm_q.push_back(pm_e);
    endtask

    // Monitor, scoreboard and downstream models, evaluated just after each edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (prd_start) begin n_prd_start++; t_prd_start = cyc; end
        if (prd_clr)   begin n_prd_clr++;   t_prd_clr   = cyc; end
        if (div_start) begin n_div_start++; last_dvsr   = div_dvsr; end
        if (prd_start && !prd_ready) n_viol++;
        if (div_start && !div_ready) n_viol++;
        if (done_tick) begin
            n_done++;
            t_done = cyc;
            if (sb_q.size() == 0) begin
                chk_eq("sb_extra_done", sb_q.size(), 1);
            end else begin
                sb_e = sb_q.pop_front();
                chk_eq("sb_freq", freq, sb_e.f);
                chk_eq("sb_err", err, sb_e.e);
            end
        end
        if (reset) begin
            pm_active = 0; pm_never = 0; dv_active = 0; pm_hold = 0; dv_hold = 0;
            prd_done_tick = 0; div_done_tick = 0; prd_ready = 1; div_ready = 1;
            pm_q.delete();
        end else begin
            prd_done_tick = 0;
            div_done_tick = 0;
            if (pm_hold > 0) pm_hold--;
            if (dv_hold > 0) dv_hold--;
            if (pm_active && !pm_never) begin
                pm_cnt--;
                if (pm_cnt <= 0) begin
                    prd_done_tick = 1;
                    prd = pm_val;
                    pm_active = 0;
                    dv_hold = cfg_div_hold;
                end
            end
            if (prd_clr) begin pm_active = 0; pm_never = 0; end
            if (prd_start) begin
                pm_active = 1;
                if (pm_q.size() > 0) begin
                    pm_e = pm_q.pop_front();
                    pm_cnt = pm_e.dly;
                    pm_val = pm_e.val;
                    pm_never = 0;
                end else begin
                    pm_never = 1;
                end
            end
            if (dv_active) begin
                dv_cnt--;
                if (dv_cnt <= 0) begin
                    div_done_tick = 1;
                    div_quo = dv_res;
                    dv_active = 0;
                end
            end
            if (div_start) begin
                dv_active = 1;
                dv_cnt = DIV_LAT;
                dv_res = (div_dvsr == 0) ? 20'hFFFFF : 20'(int'(div_dvnd) / int'(div_dvsr));
            end
            if (done_tick && cfg_prd_hold > 0) pm_hold = cfg_prd_hold;
            if (stray_req) begin
                prd_done_tick = 1; prd = 10'd5;
                div_done_tick = 1; div_quo = 20'd7;
                stray_req = 0;
            end
            prd_ready = !pm_active && (pm_hold == 0);
            div_ready = !dv_active && (dv_hold == 0);
        end
    end

    initial begin
        int b_ps, b_ds, b_clr, b_done, gap;
        reset = 1'b1; start = 1'b0; cont = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_freq", freq, 0);
        chk_eq("rst_err", err, 0);
        chk_eq("rst_pulses", {prd_start, prd_clr, div_start, done_tick}, 0);
        reset = 1'b0;
        @(negedge clk);

        // stray result ticks in IDLE are ignored
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        chk_eq("stray_busy", busy, 0);
        chk_eq("stray_done", n_done, 0);
        chk_eq("stray_freq", freq, 0);

        // single shot: prd=10 -> 100000 Hz
        push_exp(20'd100000, 2'd0);
        push_prd(1000, 10'd10);
        pulse_start();
        wait_evt(0, 1, 2000, "ss_wait_done");
        repeat (2) @(negedge clk);
        chk_eq("ss_busy_after", busy, 0);
        chk_eq("ss_dvsr", last_dvsr, 10);
        chk_eq("ss_dvnd", div_dvnd, DVND);
        repeat (20) @(negedge clk);
        chk_eq("ss_prd_starts", n_prd_start, 1);
        chk_eq("ss_div_starts", n_div_start, 1);
        chk_eq("ss_done_once", n_done, 1);

        // zero period: no divide, err=2, freq held
        b_ds = n_div_start; b_done = n_done;
        push_exp(exp_freq, 2'd2);
        push_prd(100, 10'd0);
        pulse_start();
        wait_evt(0, b_done + 1, 500, "zero_wait_done");
        repeat (20) @(negedge clk);
        chk_eq("zero_no_div", n_div_start, b_ds);
        chk_eq("zero_done_once", n_done, b_done + 1);

        // timeout: counter never answers
        b_clr = n_prd_clr; b_done = n_done; b_ds = n_div_start;
        push_exp(exp_freq, 2'd1);
        pulse_start();
        wait_evt(0, b_done + 1, TC + 1000, "to_wait_done");
        repeat (20) @(negedge clk);
        chk_eq("to_clr_once", n_prd_clr, b_clr + 1);
        gap = t_prd_clr - t_prd_start;
        chk_eq("to_clr_gap_ok", (gap >= TC - 1) && (gap <= TC + 1), 1);
        chk_eq("to_no_div", n_div_start, b_ds);
        chk_eq("to_done_once", n_done, b_done + 1);

        // result in the exact timeout cycle wins
        b_clr = n_prd_clr; b_ds = n_div_start; b_done = n_done;
        push_exp(20'd1000, 2'd0);
        push_prd(TC, 10'd1000);
        pulse_start();
        wait_evt(0, b_done + 1, TC + 1000, "sim_wait_done");
        repeat (5) @(negedge clk);
        chk_eq("sim_no_clr", n_prd_clr, b_clr);
        chk_eq("sim_div_start", n_div_start, b_ds + 1);
        chk_eq("sim_dvsr", last_dvsr, 1000);

        // continuous with ready stalls, cont dropped during the third run
        b_ps = n_prd_start; b_done = n_done;
        push_exp(20'd1000000, 2'd0);
        push_exp(20'd2000, 2'd0);
        push_exp(20'd977, 2'd0);
        push_prd(200, 10'd1);
        push_prd(200, 10'd500);
        push_prd(200, 10'd1023);
        cfg_prd_hold = 5; cfg_div_hold = 3; pm_hold = 5;
        cont = 1'b1;
        pulse_start();
        wait_evt(0, b_done + 1, 1000, "cont_wait_done1");
        wait_evt(1, b_ps + 2, 100, "cont_wait_start2");
        gap = t_prd_start - t_done;
        chk_eq("cont_stall_gap_ok", gap >= 6, 1);
        wait_evt(1, b_ps + 3, 1000, "cont_wait_start3");
        cont = 1'b0;
        pulse_start();
        wait_evt(0, b_done + 3, 1000, "cont_wait_done3");
        repeat (30) @(negedge clk);
        chk_eq("cont_idle", busy, 0);
        chk_eq("cont_prd_starts", n_prd_start, b_ps + 3);
        chk_eq("cont_done_cnt", n_done, b_done + 3);
        chk_eq("ready_violations", n_viol, 0);
        cfg_prd_hold = 0; cfg_div_hold = 0;

        // async reset while the divider is running
        b_ds = n_div_start;
        push_prd(300, 10'd8);
        pulse_start();
        wait_evt(2, b_ds + 1, 1000, "rst_wait_div");
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_freq", freq, 0);
        chk_eq("arst_err", err, 0);
        chk_eq("arst_pulses", {prd_start, prd_clr, div_start, done_tick}, 0);
        chk_eq("arst_dvsr", div_dvsr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (DIV_LAT + 5) @(negedge clk);

        // clean run after reset: prd=250 -> 4000 Hz
        b_done = n_done; b_clr = n_prd_clr;
        push_exp(20'd4000, 2'd0);
        push_prd(300, 10'd250);
        pulse_start();
        wait_evt(0, b_done + 1, 1000, "post_wait_done");
        repeat (5) @(negedge clk);
        chk_eq("post_busy", busy, 0);
        chk_eq("post_no_clr", n_prd_clr, b_clr);
        chk_eq("sb_drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
